// File: rtl/issue_queue_pkg.sv
// Shared types and constants for the decode -> issue queue.
package issue_queue_pkg;

  localparam int IQ_DEPTH = 8;

  typedef logic bool;

  // One decoded instruction as handed from decode to issue.
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    bool         is_branch;
    bool         is_delay_slot;
  } ISSUE_QUEUE_ELEMENT;

  // Number of set lanes in a 2-lane valid vector.
  function automatic logic [1:0] popcount2(input logic [1:0] v);
    return {1'b0, v[0]} + {1'b0, v[1]};
  endfunction

endpackage

// File: rtl/issue_queue_if.sv
// Decode/issue side bundle of the issue queue; master drives pushes and pops.
interface issue_queue_if #(
  parameter int DEPTH = issue_queue_pkg::IQ_DEPTH,
  parameter int CNT_W = $clog2(DEPTH + 1)
) ();
  import issue_queue_pkg::*;

  logic                          flash;
  logic                          stall;
  logic [1:0]                    push_ena;
  ISSUE_QUEUE_ELEMENT [1:0]      push_data;
  logic                          push_ready;
  ISSUE_QUEUE_ELEMENT [1:0]      issue_require;
  logic [1:0]                    iq_size;
  logic [1:0]                    iq_pop_number;
  logic [CNT_W-1:0]              count;

  modport master (
    output flash, stall, push_ena, push_data, iq_pop_number,
    input  push_ready, issue_require, iq_size, count
  );

  modport slave (
    input  flash, stall, push_ena, push_data, iq_pop_number,
    output push_ready, issue_require, iq_size, count
  );

endinterface

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for the issue queue, including pop clamping
// and flush priority. Produces write enables for the two tail slots.
module iq_ptr_ctrl
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flash_i,
  input  logic             stall_i,
  input  logic [1:0]       push_ena_i,
  input  logic [1:0]       pop_num_i,
  output logic [PTR_W-1:0] head_o,
  output logic [PTR_W-1:0] tail_o,
  output logic [CNT_W-1:0] count_o,
  output logic [1:0]       iq_size_o,
  output logic             push_ready_o,
  output logic [1:0]       wr_en_o,
  output logic             wr_lane1_first_o
);

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [1:0]       iq_size;
  logic [1:0]       pop_eff;
  logic [1:0]       push_eff;
  logic             push_ready;

  // Occupancy-derived status, effective push/pop amounts and next pointers.
  always_comb begin
    push_ready = (count_q <= CNT_W'(DEPTH - 2));
    iq_size    = (count_q >= CNT_W'(2)) ? 2'd2 : count_q[1:0];
    // Issue may never pop more than it sees; clamp to stay consistent anyway.
    pop_eff    = (pop_num_i > iq_size) ? iq_size : pop_num_i;
    if (stall_i) pop_eff = 2'd0;
    push_eff   = push_ready ? popcount2(push_ena_i) : 2'd0;

    head_d  = head_q + PTR_W'(pop_eff);
    tail_d  = tail_q + PTR_W'(push_eff);
    count_d = count_q + CNT_W'(push_eff) - CNT_W'(pop_eff);

    // Flush discards everything, including this cycle's pushes and pops.
    if (flash_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end

    // Lanes are compacted: the first set lane goes to tail, a second to tail+1.
    wr_en_o[0]       = push_ready && !flash_i && (push_ena_i != 2'b00);
    wr_en_o[1]       = push_ready && !flash_i && (push_ena_i == 2'b11);
    wr_lane1_first_o = (push_ena_i == 2'b10);
  end

  // Control state registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  assign head_o       = head_q;
  assign tail_o       = tail_q;
  assign count_o      = count_q;
  assign iq_size_o    = iq_size;
  assign push_ready_o = push_ready;

endmodule

// File: rtl/issue_queue.sv
// In-order dual-push / dual-pop circular buffer between decode and issue.
// Storage is a plain flop array; pointer arithmetic lives in iq_ptr_ctrl.
module issue_queue
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = IQ_DEPTH,
  parameter int PTR_W = $clog2(DEPTH),
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  issue_queue_if.slave iq
);

  ISSUE_QUEUE_ELEMENT mem_q [DEPTH];

  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [PTR_W-1:0] head_p1;
  logic [PTR_W-1:0] tail_p1;
  logic [CNT_W-1:0] count;
  logic [1:0]       iq_size;
  logic             push_ready;
  logic [1:0]       wr_en;
  logic             wr_lane1_first;

  iq_ptr_ctrl #(
    .DEPTH(DEPTH),
    .PTR_W(PTR_W),
    .CNT_W(CNT_W)
  ) u_ptr_ctrl (
    .clk              (clk),
    .rst              (rst),
    .flash_i          (iq.flash),
    .stall_i          (iq.stall),
    .push_ena_i       (iq.push_ena),
    .pop_num_i        (iq.iq_pop_number),
    .head_o           (head),
    .tail_o           (tail),
    .count_o          (count),
    .iq_size_o        (iq_size),
    .push_ready_o     (push_ready),
    .wr_en_o          (wr_en),
    .wr_lane1_first_o (wr_lane1_first)
  );

  // Pointer increments wrap naturally at DEPTH (power of two).
  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);

  // Entry storage; contents are don't-care after reset, so no reset here.
  always_ff @(posedge clk) begin
    if (wr_en[0]) mem_q[tail]    <= wr_lane1_first ? iq.push_data[1] : iq.push_data[0];
    if (wr_en[1]) mem_q[tail_p1] <= iq.push_data[1];
  end

  // Zero-latency read of the two oldest entries, blanked when not present.
  always_comb begin
    iq.issue_require = '0;
    if (iq_size != 2'd0) iq.issue_require[0] = mem_q[head];
    if (iq_size[1])      iq.issue_require[1] = mem_q[head_p1];
  end

  assign iq.iq_size    = iq_size;
  assign iq.push_ready = push_ready;
  assign iq.count      = count;

endmodule
